breakout_ctrl: RTL and testbench

Game-control stage directly downstream of `pong_graph`. It consumes the graph's `hit`/`miss` flags and the player buttons, and runs the game state machine (new game, play, new ball, cleared, over). It keeps a 2-digit BCD score and a ball counter, and drives `gra_still` back into the graph to freeze and re-centre the ball and paddle between rounds. Its outputs also feed the score/text overlay.

---
 rtl/breakout_pkg.sv | 26 ++
 rtl/breakout_ctrl_bcd_counter2.sv | 37 +++
 rtl/breakout_ctrl.sv | 169 ++++++++++++++++
 tb/tb_breakout_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/breakout_pkg.sv
// Shared constants and state encoding for the breakout game blocks.
// pong_graph is expected to pick up the same screen/brick constants.
package breakout_pkg;

    localparam int unsigned MAX_X      = 640;
    localparam int unsigned MAX_Y      = 480;
    localparam int unsigned REFR_Y     = 481;
    localparam int unsigned NUM_BRICKS = 48;

    localparam int unsigned PIX_W      = 10;
    localparam int unsigned BTN_W      = 5;
    localparam int unsigned STATE_W    = 3;
    localparam int unsigned SCORE_W    = 8;
    localparam int unsigned BALLS_W    = 2;
    localparam int unsigned TIMER_W    = 7;
    localparam int unsigned HIT_CNT_W  = 6;

    typedef enum logic [STATE_W-1:0] {
        ST_NEWGAME = 3'd0,
        ST_PLAY    = 3'd1,
        ST_NEWBALL = 3'd2,
        ST_OVER    = 3'd3,
        ST_CLEAR   = 3'd4
    } state_t;

endpackage

// File: rtl/breakout_ctrl_bcd_counter2.sv
// Two-digit BCD counter with synchronous clear and saturation at 99.
module bcd_counter2
    import breakout_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               clr,
    input  logic               inc,
    output logic [SCORE_W-1:0] value
);

    logic [3:0] ones_q;
    logic [3:0] tens_q;
    logic       at_max;

    assign at_max = (tens_q == 4'd9) && (ones_q == 4'd9);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ones_q <= '0;
            tens_q <= '0;
        end else if (clr) begin
            ones_q <= '0;
            tens_q <= '0;
        end else if (inc && !at_max) begin
            if (ones_q == 4'd9) begin
                ones_q <= '0;
                tens_q <= tens_q + 4'd1;
            end else begin
                ones_q <= ones_q + 4'd1;
            end
        end
    end

    assign value = {tens_q, ones_q};

endmodule

// File: rtl/breakout_ctrl.sv
// Game-control FSM downstream of pong_graph: frame tick, hit/miss edge
// detection, between-round timer, score and ball bookkeeping.
module breakout_ctrl
    import breakout_pkg::*;
#(
    parameter int unsigned BALLS_INIT   = 3,
    parameter int unsigned TIMER_TICKS  = 120,
    parameter int unsigned BRICKS_TOTAL = NUM_BRICKS
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BTN_W-1:0]   btn,
    input  logic [PIX_W-1:0]   pix_x,
    input  logic [PIX_W-1:0]   pix_y,
    input  logic               hit,
    input  logic               miss,
    output logic               gra_still,
    output logic [SCORE_W-1:0] score_bcd,
    output logic [BALLS_W-1:0] balls_left,
    output logic [STATE_W-1:0] game_state,
    output logic               game_over,
    output logic               cleared
);

    state_t                 state_q;
    state_t                 state_d;
    logic                   tick_cond;
    logic                   tick_cond_q;
    logic                   fr_tick;
    logic                   hit_q;
    logic                   miss_q;
    logic                   hit_ev;
    logic                   miss_ev;
    logic                   press;
    logic [TIMER_W-1:0]     timer_q;
    logic                   timer_zero;
    logic [HIT_CNT_W-1:0]   hit_cnt_q;
    logic                   hit_last;
    logic                   start_game;
    logic                   load_timer;
    logic                   dec_ball;
    logic                   count_hit;

    // Edge-detect the refresh coordinate so a slow pixel enable still yields one tick.
    assign tick_cond = (pix_y == PIX_W'(REFR_Y)) && (pix_x == '0);
    assign fr_tick   = tick_cond && !tick_cond_q;
    assign hit_ev    = hit && !hit_q;
    assign miss_ev   = miss && !miss_q;
    assign press     = |btn;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cond_q <= 1'b0;
            hit_q       <= 1'b0;
            miss_q      <= 1'b0;
        end else begin
            tick_cond_q <= tick_cond;
            hit_q       <= hit;
            miss_q      <= miss;
        end
    end

    assign timer_zero = (timer_q == '0);
    assign hit_last   = ((hit_cnt_q + HIT_CNT_W'(1)) == HIT_CNT_W'(BRICKS_TOTAL));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_NEWGAME;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and datapath strobes; a clearing hit overrides a simultaneous miss.
    always_comb begin
        state_d    = state_q;
        start_game = 1'b0;
        load_timer = 1'b0;
        dec_ball   = 1'b0;
        count_hit  = 1'b0;
        case (state_q)
            ST_NEWGAME: begin
                if (press) begin
                    start_game = 1'b1;
                    state_d    = ST_PLAY;
                end
            end
            ST_PLAY: begin
                count_hit = hit_ev;
                if (miss_ev) begin
                    dec_ball   = 1'b1;
                    load_timer = 1'b1;
                    state_d    = (balls_left > BALLS_W'(1)) ? ST_NEWBALL : ST_OVER;
                end
                if (hit_ev && hit_last) begin
                    load_timer = 1'b1;
                    state_d    = ST_CLEAR;
                end
            end
            ST_NEWBALL: begin
                if (timer_zero && press) begin
                    state_d = ST_PLAY;
                end
            end
            ST_OVER, ST_CLEAR: begin
                if (timer_zero) begin
                    state_d = ST_NEWGAME;
                end
            end
            default: begin
                state_d = ST_NEWGAME;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= '0;
        end else if (load_timer) begin
            timer_q <= TIMER_W'(TIMER_TICKS);
        end else if (fr_tick && !timer_zero) begin
            timer_q <= timer_q - TIMER_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hit_cnt_q <= '0;
        end else if (start_game) begin
            hit_cnt_q <= '0;
        end else if (count_hit) begin
            hit_cnt_q <= hit_cnt_q + HIT_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            balls_left <= BALLS_W'(BALLS_INIT);
        end else if (start_game) begin
            balls_left <= BALLS_W'(BALLS_INIT);
        end else if (dec_ball && (balls_left != '0)) begin
            balls_left <= balls_left - BALLS_W'(1);
        end
    end

    bcd_counter2 u_score (
        .clk   (clk),
        .reset (reset),
        .clr   (start_game),
        .inc   (count_hit),
        .value (score_bcd)
    );

    // Moore flags trail the state register by one clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gra_still <= 1'b1;
            game_over <= 1'b0;
            cleared   <= 1'b0;
        end else begin
            gra_still <= (state_q != ST_PLAY);
            game_over <= (state_q == ST_OVER);
            cleared   <= (state_q == ST_CLEAR);
        end
    end

    assign game_state = state_q;

endmodule

// File: tb/tb_breakout_ctrl.sv
// Scoreboard bench for breakout_ctrl with a shortened between-round timer.
module tb_breakout_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] btn;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       hit;
    logic       miss;
    logic       gra_still;
    logic [7:0] score_bcd;
    logic [1:0] balls_left;
    logic [2:0] game_state;
    logic       game_over;
    logic       cleared;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int st;
        int sc;
        int bl;
        int gs;
        int go;
        int cl;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    breakout_ctrl #(
        .BALLS_INIT   (3),
        .TIMER_TICKS  (4),
        .BRICKS_TOTAL (48)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn        (btn),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .hit        (hit),
        .miss       (miss),
        .gra_still  (gra_still),
        .score_bcd  (score_bcd),
        .balls_left (balls_left),
        .game_state (game_state),
        .game_over  (game_over),
        .cleared    (cleared)
    );

    always #5 clk = ~clk;

    function automatic int to_bcd(input int n);
        return ((n / 10) << 4) | (n % 10);
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int st, input int sc, input int bl,
                              input int gs, input int go, input int cl);
        exp_t e;
        e.st = st; e.sc = sc; e.bl = bl; e.gs = gs; e.go = go; e.cl = cl;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic drain();
        exp_t  e;
        string t;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check_eq({t, ".state"},     32'(game_state), e.st);
            check_eq({t, ".score"},     32'(score_bcd),  e.sc);
            check_eq({t, ".balls"},     32'(balls_left), e.bl);
            check_eq({t, ".gra_still"}, 32'(gra_still),  e.gs);
            check_eq({t, ".game_over"}, 32'(game_over),  e.go);
            check_eq({t, ".cleared"},   32'(cleared),    e.cl);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One compressed frame; the refresh coordinate is held two clocks.
    task automatic frame();
        pix_y = 10'd481;
        pix_x = 10'd0;
        tick();
        tick();
        pix_y = 10'd0;
        pix_x = 10'd5;
        tick();
    endtask

    task automatic hit_pulse(input int len);
        hit = 1'b1;
        repeat (len) tick();
        hit = 1'b0;
        tick();
    endtask

    task automatic press_start();
        btn = 5'h01;
        tick();
        btn = 5'h00;
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: bench did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        btn   = 5'h00;
        hit   = 1'b0;
        miss  = 1'b0;
        pix_x = 10'd5;
        pix_y = 10'd0;
        expect_out("rst", 0, 0, 3, 1, 0, 0);
        repeat (2) tick();
        drain();

        reset = 1'b0;
        tick();
        expect_out("idle", 0, 0, 3, 1, 0, 0);
        repeat (3) frame();
        drain();

        btn = 5'h01;
        expect_out("start", 1, 0, 3, 1, 0, 0);
        tick();
        drain();
        btn = 5'h00;
        expect_out("play", 1, 0, 3, 0, 0, 0);
        tick();
        drain();

        hit = 1'b1;
        expect_out("hit1", 1, 1, 3, 0, 0, 0);
        tick();
        drain();
        repeat (49) tick();
        hit = 1'b0;
        expect_out("hitlong", 1, 1, 3, 0, 0, 0);
        tick();
        drain();
        for (int i = 2; i <= 12; i++) begin
            hit_pulse(50);
            if (i == 9 || i == 10) begin
                expect_out((i == 9) ? "h09" : "h10", 1, to_bcd(i), 3, 0, 0, 0);
                drain();
            end
        end
        expect_out("h12", 1, to_bcd(12), 3, 0, 0, 0);
        drain();

        miss = 1'b1;
        expect_out("miss1", 2, 'h12, 2, 0, 0, 0);
        tick();
        drain();
        miss = 1'b0;
        expect_out("nb", 2, 'h12, 2, 1, 0, 0);
        tick();
        drain();
        frame();
        frame();
        btn = 5'h01;
        expect_out("early", 2, 'h12, 2, 1, 0, 0);
        tick();
        drain();
        btn = 5'h00;
        tick();
        frame();
        frame();
        btn = 5'h01;
        expect_out("resume", 1, 'h12, 2, 1, 0, 0);
        tick();
        drain();
        btn = 5'h00;
        expect_out("play2", 1, 'h12, 2, 0, 0, 0);
        tick();
        drain();

        miss = 1'b1;
        tick();
        miss = 1'b0;
        expect_out("miss2", 2, 'h12, 1, 1, 0, 0);
        tick();
        drain();
        repeat (4) frame();
        expect_out("play3", 1, 'h12, 1, 0, 0, 0);
        press_start();
        drain();
        miss = 1'b1;
        expect_out("over", 3, 'h12, 0, 0, 0, 0);
        tick();
        drain();
        miss = 1'b0;
        expect_out("over2", 3, 'h12, 0, 1, 1, 0);
        tick();
        drain();
        expect_out("over3", 3, 'h12, 0, 1, 1, 0);
        repeat (3) frame();
        drain();
        expect_out("ng", 0, 'h12, 0, 1, 0, 0);
        frame();
        drain();
        btn = 5'h01;
        expect_out("restart", 1, 0, 3, 1, 0, 0);
        tick();
        drain();
        btn = 5'h00;
        tick();

        for (int i = 0; i < 47; i++) begin
            hit_pulse(1);
        end
        expect_out("h47", 1, to_bcd(47), 3, 0, 0, 0);
        drain();
        hit  = 1'b1;
        miss = 1'b1;
        expect_out("clr", 4, to_bcd(48), 2, 0, 0, 0);
        tick();
        drain();
        hit  = 1'b0;
        miss = 1'b0;
        expect_out("clr2", 4, to_bcd(48), 2, 1, 0, 1);
        tick();
        drain();
        expect_out("ngc", 0, to_bcd(48), 2, 1, 0, 0);
        repeat (4) frame();
        drain();

        press_start();
        for (int i = 0; i < 7; i++) begin
            hit_pulse(1);
        end
        expect_out("h7", 1, 'h07, 3, 0, 0, 0);
        drain();
        pix_y = 10'd200;
        pix_x = 10'd300;
        #2;
        reset = 1'b1;
        expect_out("arst", 0, 0, 3, 1, 0, 0);
        #1;
        drain();
        tick();
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
